signed_divider: RTL and testbench

Sequential signed integer divider, the inverse counterpart of the team's sequential Booth multiplier: `Q = A / B`, `R = A % B`, truncating toward zero. It uses the same `load`/`done` handshake as the multiplier, so both can sit behind one arithmetic-unit controller. It is a radix-2 restoring divider on operand magnitudes, with a final sign-correction step.

---
 rtl/arith_pkg.sv | 13 +
 rtl/twos_negate.sv | 10 +
 rtl/signed_divider.sv | 132 +++++++++++++
 tb/tb_signed_divider.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: FSM state encoding and load/done handshake levels shared by the sequential arithmetic units
package arith_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    FIX   = 3'd4,
    DONE  = 3'd5
  } state_e;
  localparam logic LOAD_ACTIVE = 1'b1;
  localparam logic DONE_ACTIVE = 1'b1;
endpackage

// File: rtl/twos_negate.sv
// twos_negate: combinational conditional two's-complement negate, modulo 2^W
module twos_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/signed_divider.sv
// signed_divider: radix-2 restoring signed divider with load/done handshake; SIGNED_DIVIDER_DZ_EN adds dz and early exit on B==0
module signed_divider
  import arith_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R
`ifdef SIGNED_DIVIDER_DZ_EN
  ,
  output logic         dz
`endif
);
  localparam int CW = $clog2(N);
  state_e state_q, state_d;
  logic [N-1:0] quo_q, quo_d, dvs_q, dvs_d, q_q, q_d, r_q, r_d;
  logic [N:0] rem_q, rem_d, t;
  logic [CW-1:0] cnt_q, cnt_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;
  logic [N-1:0] abs_a, abs_b, quo_fix, rem_fix;
  twos_negate #(.W(N)) u_abs_a (.neg(A[N-1]), .x(A), .y(abs_a));
  twos_negate #(.W(N)) u_abs_b (.neg(B[N-1]), .x(B), .y(abs_b));
  twos_negate #(.W(N)) u_fix_q (.neg(qneg_q), .x(quo_q), .y(quo_fix));
  twos_negate #(.W(N)) u_fix_r (.neg(rneg_q), .x(rem_q[N-1:0]), .y(rem_fix));
`ifdef SIGNED_DIVIDER_DZ_EN
  logic dz_q, dz_d;
  assign dz = dz_q;
`endif
  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = done_q;
`ifdef SIGNED_DIVIDER_DZ_EN
    dz_d    = dz_q;
`endif
    t       = rem_q - {1'b0, dvs_q};
    case (state_q)
      IDLE: begin
        done_d  = 1'b0;
        state_d = (load == LOAD_ACTIVE) ? INIT : IDLE;
      end
      INIT: begin
        done_d  = 1'b0;
        quo_d   = abs_a;
        dvs_d   = abs_b;
        qneg_d  = A[N-1] ^ B[N-1];
        rneg_d  = A[N-1];
        rem_d   = '0;
        cnt_d   = CW'(N - 1);
        state_d = SHIFT;
`ifdef SIGNED_DIVIDER_DZ_EN
        // zero divisor skips the iterations and reports the all-ones quotient directly
        dz_d = (B == '0);
        if (B == '0) begin
          quo_d   = '1;
          rem_d   = {1'b0, A};
          state_d = DONE;
        end
`endif
      end
      SHIFT: begin
        {rem_d, quo_d} = {rem_q[N-1:0], quo_q, 1'b0};
        state_d = SUB;
      end
      SUB: begin
        rem_d   = t[N] ? rem_q : t;
        quo_d   = {quo_q[N-1:1], ~t[N]};
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? FIX : SHIFT;
      end
      FIX: begin
        quo_d   = quo_fix;
        rem_d   = {1'b0, rem_fix};
        state_d = DONE;
      end
      DONE: begin
        q_d     = quo_q;
        r_d     = rem_q[N-1:0];
        done_d  = DONE_ACTIVE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
`ifdef SIGNED_DIVIDER_DZ_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
`ifdef SIGNED_DIVIDER_DZ_EN
      dz_q    <= dz_d;
`endif
    end
  end
  assign done = done_q;
  assign Q    = q_q;
  assign R    = r_q;
endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: directed and random checks of signed_divider against a plain-arithmetic reference
module tb_signed_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  logic [31:0] A = '0, B = '0, Q, R;
  logic done;
  int checks = 0, failures = 0;
`ifdef SIGNED_DIVIDER_DZ_EN
  localparam bit DZ = 1'b1;
  logic dz;
  signed_divider #(.N(32)) dut (.clk(clk), .rst_n(rst_n), .load(load), .A(A), .B(B), .done(done), .Q(Q), .R(R), .dz(dz));
`else
  localparam bit DZ = 1'b0;
  signed_divider #(.N(32)) dut (.clk(clk), .rst_n(rst_n), .load(load), .A(A), .B(B), .done(done), .Q(Q), .R(R));
`endif
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // truncating division in 64-bit so that -2^31 / -1 wraps to 0x8000_0000
  function automatic void model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) begin
      q = (DZ || !a[31]) ? 32'hFFFF_FFFF : 32'd1;
      r = a;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic wait_done(inout int lat);
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!done && lat < 200);
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b, input int lat);
    logic [31:0] eq, er;
    model(a, b, eq, er);
    chk({tag, "_latency"}, lat, (DZ && b == 0) ? 2 : 67);
    chk({tag, "_Q"}, Q, eq);
    chk({tag, "_R"}, R, er);
`ifdef SIGNED_DIVIDER_DZ_EN
    chk({tag, "_dz"}, dz, b == 0);
`endif
    @(posedge clk);
    #1 chk({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat = 0;
    start(a, b);
    wait_done(lat);
    check_result(tag, a, b, lat);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [31:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", done, 0);
    chk("reset_Q", Q, 0);
    chk("reset_R", R, 0);
`ifdef SIGNED_DIVIDER_DZ_EN
    chk("reset_dz", dz, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("p100_p7", 32'd100, 32'd7);
    run("n100_p7", -32'sd100, 32'd7);
    run("p100_n7", 32'd100, -32'sd7);
    run("n100_n7", -32'sd100, -32'sd7);
    run("min_n1", 32'h8000_0000, 32'hFFFF_FFFF);
    run("min_p1", 32'h8000_0000, 32'd1);
    run("p7_p100", 32'd7, 32'd100);
    run("p5_zero", 32'd5, 32'd0);
    run("n5_zero", -32'sd5, 32'd0);
    run("min_zero", 32'h8000_0000, 32'd0);
    run("p100_min", 32'd100, 32'h8000_0000);
    // load during the division must be ignored even with new operands on the bus
    lat = 0;
    start(32'd100, 32'd7);
    repeat (20) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 1) begin
        A = 32'd999;
        B = 32'd3;
      end
      load = (lat == 10);
    end
    load = 1'b0;
    wait_done(lat);
    check_result("mid_load", 32'd100, 32'd7, lat);
    // load held high gives back-to-back results
    A = 32'd100;
    B = 32'd7;
    load = 1'b1;
    @(posedge clk);
    #1 lat = 0;
    wait_done(lat);
    chk("held_first_latency", lat, 67);
    chk("held_first_Q", Q, 14);
    lat = 0;
    wait_done(lat);
    load = 1'b0;
    chk("held_period", lat, 68);
    chk("held_second_Q", Q, 14);
    chk("held_second_R", R, 2);
    @(posedge clk);
    #1 chk("held_done_pulse", done, 0);
    // reset at iteration 10 clears everything and leaves the divider idle
    start(32'd100, 32'd7);
    repeat (21) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_done", done, 0);
    chk("midrst_Q", Q, 0);
    chk("midrst_R", R, 0);
`ifdef SIGNED_DIVIDER_DZ_EN
    chk("midrst_dz", dz, 0);
`endif
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1 seen |= done;
    end
    chk("midrst_no_done", seen, 0);
    run("after_rst", 32'd100, 32'd7);
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(0, 40)) - 32'd20;
        2: rb = $urandom >> $urandom_range(1, 31);
        default: rb = 32'($urandom_range(1, 9));
      endcase
      if (i % 8 == 3) ra = 32'h8000_0000;
      run("rand", ra, rb);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
